// File: rtl/siso_shift_ctrl_if.sv
// ============================================================================
// Module      : siso_shift_ctrl_if
// Description : Parallel-in / serial-out handshake bundle for siso_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface siso_shift_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;
  logic             busy;
  logic             done;

  // slave is the controller; master is the producer/consumer environment
  modport slave (
    input  din, din_valid, sout_ready,
    output din_ready, sout, sout_valid, sout_last, busy, done
  );

  modport master (
    output din, din_valid, sout_ready,
    input  din_ready, sout, sout_valid, sout_last, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/siso_shift_ctrl.sv
// ============================================================================
// Module      : siso_shift_ctrl
// Description : Serializer controller, MSB-first, valid/ready on both sides.
//               Optional even-parity trailer bit via SISO_CTRL_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siso_shift_ctrl #(
  parameter int WIDTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  siso_shift_ctrl_if.slave bus
);

  localparam int            c_CW       = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
`ifdef SISO_CTRL_PARITY_EN
  localparam logic [1:0] c_PAR   = 2'd2;
`endif
  localparam logic [1:0] c_DONE  = 2'd3;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("siso_shift_ctrl: WIDTH out of range 2..32");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [c_CW-1:0]  r_cnt;
  logic             w_accept;
  logic             w_shift_fire;
  logic             w_cnt_last;
`ifdef SISO_CTRL_PARITY_EN
  logic             r_par;
`endif

  // rst gates the accept so a reset edge never loads a word
  assign w_accept     = (r_state == c_IDLE) && bus.din_valid && !rst;
  assign w_shift_fire = (r_state == c_SHIFT) && bus.sout_ready;
  assign w_cnt_last   = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) w_next_state = c_SHIFT;
      end
      c_SHIFT: begin
        if (w_shift_fire && w_cnt_last) begin
`ifdef SISO_CTRL_PARITY_EN
          w_next_state = c_PAR;
`else
          w_next_state = c_DONE;
`endif
        end
      end
`ifdef SISO_CTRL_PARITY_EN
      c_PAR: begin
        if (bus.sout_ready) w_next_state = c_DONE;
      end
`endif
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
`ifdef SISO_CTRL_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shreg <= bus.din;
      r_cnt   <= '0;
`ifdef SISO_CTRL_PARITY_EN
      r_par   <= ^bus.din;
`endif
    end else if (w_shift_fire) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      r_cnt   <= r_cnt + c_CW'(1);
    end
  end

  always_comb begin
    bus.din_ready  = (r_state == c_IDLE) && !rst;
    bus.busy       = (r_state != c_IDLE);
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.sout_last  = 1'b0;
    bus.done       = 1'b0;
    case (r_state)
      c_SHIFT: begin
        bus.sout       = r_shreg[WIDTH-1];
        bus.sout_valid = 1'b1;
`ifndef SISO_CTRL_PARITY_EN
        bus.sout_last  = w_cnt_last;
`endif
      end
`ifdef SISO_CTRL_PARITY_EN
      c_PAR: begin
        bus.sout       = r_par;
        bus.sout_valid = 1'b1;
        bus.sout_last  = 1'b1;
      end
`endif
      c_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_siso_shift_ctrl.sv
// ============================================================================
// Module      : tb_siso_shift_ctrl
// Description : Directed self-checking bench for siso_shift_ctrl (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_siso_shift_ctrl;

`ifdef SISO_CTRL_PARITY_EN
  localparam int         NB      = 5;
  localparam int         SPACE   = 7;
  localparam logic [4:0] FR_1011 = 5'b10111;
  localparam logic [4:0] FR_0110 = 5'b01100;
  localparam logic [4:0] FR_0001 = 5'b00011;
  localparam logic [4:0] FR_1100 = 5'b11000;
`else
  localparam int         NB      = 4;
  localparam int         SPACE   = 6;
  localparam logic [4:0] FR_1011 = 5'b01011;
  localparam logic [4:0] FR_0110 = 5'b00110;
  localparam logic [4:0] FR_0001 = 5'b00001;
  localparam logic [4:0] FR_1100 = 5'b01100;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  siso_shift_ctrl_if #(.WIDTH(4)) bus ();

  siso_shift_ctrl #(.WIDTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_sout"},  32'(bus.sout), 0);
    check_eq({tag, "_valid"}, 32'(bus.sout_valid), 0);
    check_eq({tag, "_last"},  32'(bus.sout_last), 0);
    check_eq({tag, "_busy"},  32'(bus.busy), 0);
    check_eq({tag, "_done"},  32'(bus.done), 0);
  endtask

  // Accept a word, then walk the frame bit by bit with sout_ready held high.
  task automatic run_frame(input string tag, input logic [3:0] w, input logic [4:0] bits);
    bus.din        = w;
    bus.din_valid  = 1'b1;
    bus.sout_ready = 1'b1;
    check_eq({tag, "_ready_in"}, 32'(bus.din_ready), 1);
    step();
    bus.din_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      check_eq($sformatf("%s_bit%0d", tag, i),   32'(bus.sout), 32'(bits[NB-1-i]));
      check_eq($sformatf("%s_valid%0d", tag, i), 32'(bus.sout_valid), 1);
      check_eq($sformatf("%s_last%0d", tag, i),  32'(bus.sout_last), 32'(i == NB - 1));
      check_eq($sformatf("%s_rdy%0d", tag, i),   32'(bus.din_ready), 0);
      step();
    end
    check_eq({tag, "_done"},      32'(bus.done), 1);
    check_eq({tag, "_done_valid"}, 32'(bus.sout_valid), 0);
    check_eq({tag, "_done_ready"}, 32'(bus.din_ready), 0);
    step();
    check_eq({tag, "_done_clr"},  32'(bus.done), 0);
    check_eq({tag, "_ready_out"}, 32'(bus.din_ready), 1);
    check_eq({tag, "_busy_out"},  32'(bus.busy), 0);
  endtask

  logic [3:0] vals [15] = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h7, 4'h3, 4'h9, 4'h6,
                            4'h1, 4'hE, 4'h2, 4'hD, 4'h8, 4'h4, 4'hB};
  logic [3:0] cap;

  initial begin
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.sout_ready = 1'b0;

    step();
    check_idle("rst");
    check_eq("rst_ready", 32'(bus.din_ready), 0);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_ready", 32'(bus.din_ready), 1);

    run_frame("basic", 4'b1011, FR_1011);
    run_frame("par0",  4'b0110, FR_0110);

    // Backpressure on the second bit for 3 cycles
    bus.din        = 4'b1100;
    bus.din_valid  = 1'b1;
    bus.sout_ready = 1'b1;
    step();
    bus.din_valid = 1'b0;
    check_eq("bp_bit0", 32'(bus.sout), 1);
    step();
    bus.sout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.sout_ready = 1'b1;
      #0;
      check_eq($sformatf("bp_hold%0d", k),  32'(bus.sout), 1);
      check_eq($sformatf("bp_valid%0d", k), 32'(bus.sout_valid), 1);
      check_eq($sformatf("bp_done%0d", k),  32'(bus.done), 0);
      step();
    end
    for (int i = 2; i < NB; i++) begin
      check_eq($sformatf("bp_bit%0d", i),  32'(bus.sout), 32'(FR_1100[NB-1-i]));
      check_eq($sformatf("bp_last%0d", i), 32'(bus.sout_last), 32'(i == NB - 1));
      step();
    end
    check_eq("bp_done", 32'(bus.done), 1);
    step();

    // Reset while the third bit is on sout
    bus.din        = 4'b1011;
    bus.din_valid  = 1'b1;
    bus.sout_ready = 1'b1;
    step();
    bus.din_valid = 1'b0;
    step();
    step();
    check_eq("mid_bit2", 32'(bus.sout), 1);
    rst = 1'b1;
    step();
    check_idle("mid_rst");
    check_eq("mid_rst_ready", 32'(bus.din_ready), 0);
    rst = 1'b0;
    #1;
    check_eq("mid_rel_ready", 32'(bus.din_ready), 1);
    check_eq("mid_rel_done",  32'(bus.done), 0);
    run_frame("after_rst", 4'b0001, FR_0001);

    // Back-to-back with din_valid held and din changing every cycle
    bus.sout_ready = 1'b1;
    cap = '0;
    for (int t = 0; t <= 2 * SPACE; t++) begin
      int off;
      off           = t % SPACE;
      bus.din       = vals[t];
      bus.din_valid = 1'b1;
      #0;
      check_eq($sformatf("b2b_ready_t%0d", t), 32'(bus.din_ready), 32'(off == 0));
      if (off == 0) cap = vals[t];
      if (t > 0 && off >= 1 && off <= 4)
        check_eq($sformatf("b2b_sout_t%0d", t), 32'(bus.sout), 32'(cap[4-off]));
      if (off == SPACE - 1)
        check_eq($sformatf("b2b_done_t%0d", t), 32'(bus.done), 1);
      step();
    end
    bus.din_valid = 1'b0;
    for (int i = 0; i < SPACE; i++) step();
    check_eq("b2b_end_busy",  32'(bus.busy), 0);
    check_eq("b2b_end_ready", 32'(bus.din_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
